// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_readout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       owner_d;   // 1: load/store owns the access in flight
  logic       is_write;
  logic       last_d;    // 1: load/store won the most recent contended pick
  logic       pick_valid;
  logic       pick_d;
  logic       contended;
  logic       unused_addr_bits;

  // Only the word-address bits reach the memory; byte offset and high bits are dropped
  assign unused_addr_bits = ^{if_addr, d_addr};

  // Choose the next owner whenever the port is in an arbitrating state
  always_comb begin
    contended  = if_req && d_req;
    pick_valid = ((state == S_IDLE) || (state == S_RESP)) && (if_req || d_req);
    pick_d     = contended ? !last_d : d_req;
  end

  // Port sequencing with all requester and memory outputs registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 3'd0;
      owner_d   <= 1'b0;
      is_write  <= 1'b0;
      last_d    <= 1'b1;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (pick_valid) begin
            state   <= S_ACCESS;
            owner_d <= pick_d;
            if (contended) last_d <= pick_d;
            if (pick_d) begin
              d_gnt    <= 1'b1;
              mem_addr <= d_addr[ADDR_W+1:2];
              is_write <= d_we;
              mem_wren <= d_we;
              mem_rden <= !d_we;
              if (d_we) mem_data <= d_wdata;
            end else begin
              if_gnt   <= 1'b1;
              mem_addr <= if_addr[ADDR_W+1:2];
              is_write <= 1'b0;
              mem_rden <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (is_write) begin
            state <= S_IDLE;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= LAT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= S_RESP;
            if (owner_d) begin
              d_rdata  <= mem_readout;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_readout;
              if_rvalid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
